// File: rtl/lpm_ctrl_pkg.sv
// Shared types and constants for the LPM route-table access controller.
// Entry layout: {oq, nh, mask, ip}, one host word each.
package lpm_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIET,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RESP
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_ACK_TO   = 2'd1;
  localparam logic [1:0] ERR_QUIET_TO = 2'd2;

  localparam int ENTRY_W  = 128;
  localparam int IP_LSB   = 0;
  localparam int MASK_LSB = 32;
  localparam int NH_LSB   = 64;
  localparam int OQ_LSB   = 96;

  function automatic int tmr_w(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/lpm_tbl_access_ctrl.sv
// Host-to-route-table command sequencer with lookup-quiet write gating,
// ack timeouts and access counters.
module lpm_tbl_access_ctrl
  import lpm_ctrl_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int TBL_ADDR_W         = 5,
  parameter int ACK_TIMEOUT        = 16,
  parameter int QUIET_TIMEOUT      = 1024
) (
  input  logic                            AXI_ACLK,
  input  logic                            AXI_RESETN,
  input  logic                            host_cmd_valid,
  output logic                            host_cmd_ready,
  input  logic                            host_cmd_wr,
  input  logic [TBL_ADDR_W-1:0]           host_cmd_addr,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0] host_cmd_data,
  output logic                            host_rsp_valid,
  input  logic                            host_rsp_ready,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] host_rsp_data,
  output logic [1:0]                      host_rsp_err,
  input  logic                            lkup_active,
  output logic                            tbl_wr_req,
  output logic [TBL_ADDR_W-1:0]           tbl_wr_addr,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
  input  logic                            tbl_wr_ack,
  output logic                            tbl_rd_req,
  output logic [TBL_ADDR_W-1:0]           tbl_rd_addr,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
  input  logic                            tbl_rd_ack,
  output logic [31:0]                     wr_count,
  output logic [31:0]                     rd_count,
  output logic [31:0]                     err_count
);

  localparam int TW = tmr_w(ACK_TIMEOUT, QUIET_TIMEOUT);
  localparam logic [TW-1:0] ACK_LIM   = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] QUIET_LIM = TW'(QUIET_TIMEOUT - 1);

  state_t        state;
  state_t        state_n;
  logic [TW-1:0] timer;
  logic          accept;
  logic          wr_done;
  logic          rd_done;
  logic          ack_to;
  logic          quiet_to;
  logic          rsp_enter;

  assign accept    = host_cmd_valid & host_cmd_ready;
  assign rsp_enter = (state_n == S_RESP) && (state != S_RESP);

  // Ack is checked before the limit so a same-cycle ack wins.
  always_comb begin
    state_n  = state;
    wr_done  = 1'b0;
    rd_done  = 1'b0;
    ack_to   = 1'b0;
    quiet_to = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_n = host_cmd_wr ? S_QUIET : S_RD_ISSUE;
      end
      S_QUIET: begin
        if (!lkup_active) begin
          state_n = S_WR_ISSUE;
        end else if (timer == QUIET_LIM) begin
          quiet_to = 1'b1;
          state_n  = S_RESP;
        end
      end
      S_WR_ISSUE: state_n = S_WR_WAIT;
      S_WR_WAIT: begin
        if (tbl_wr_ack) begin
          wr_done = 1'b1;
          state_n = S_RESP;
        end else if (timer == ACK_LIM) begin
          ack_to  = 1'b1;
          state_n = S_RESP;
        end
      end
      S_RD_ISSUE: state_n = S_RD_WAIT;
      S_RD_WAIT: begin
        if (tbl_rd_ack) begin
          rd_done = 1'b1;
          state_n = S_RESP;
        end else if (timer == ACK_LIM) begin
          ack_to  = 1'b1;
          state_n = S_RESP;
        end
      end
      S_RESP: begin
        if (host_rsp_ready)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state          <= S_IDLE;
      timer          <= '0;
      host_cmd_ready <= 1'b0;
      host_rsp_valid <= 1'b0;
      host_rsp_data  <= '0;
      host_rsp_err   <= ERR_OK;
      tbl_wr_req     <= 1'b0;
      tbl_rd_req     <= 1'b0;
      tbl_wr_addr    <= '0;
      tbl_wr_data    <= '0;
      tbl_rd_addr    <= '0;
      wr_count       <= '0;
      rd_count       <= '0;
      err_count      <= '0;
    end else begin
      state          <= state_n;
      timer          <= (state_n != state) ? '0 : timer + 1'b1;
      host_cmd_ready <= (state_n == S_IDLE);
      host_rsp_valid <= (state_n == S_RESP);
      tbl_wr_req     <= (state_n == S_WR_ISSUE);
      tbl_rd_req     <= (state_n == S_RD_ISSUE);
      if (accept && host_cmd_wr) begin
        tbl_wr_addr <= host_cmd_addr;
        tbl_wr_data <= host_cmd_data;
      end
      if (accept && !host_cmd_wr)
        tbl_rd_addr <= host_cmd_addr;
      if (rsp_enter) begin
        host_rsp_data <= rd_done ? tbl_rd_data : '0;
        host_rsp_err  <= quiet_to ? ERR_QUIET_TO :
                         ack_to   ? ERR_ACK_TO   : ERR_OK;
      end
      if (wr_done)
        wr_count <= wr_count + 32'd1;
      if (rd_done)
        rd_count <= rd_count + 32'd1;
      if ((ack_to || quiet_to) && (err_count != '1))
        err_count <= err_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_lpm_tbl_access_ctrl.sv
// Bench for lpm_tbl_access_ctrl: directed scenarios then random commands,
// checked against a table/latency model built from the access rules.
module tb_lpm_tbl_access_ctrl;

  localparam int ACK_TO   = 16;
  localparam int QUIET_TO = 1024;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         host_cmd_valid = 1'b0;
  logic         host_cmd_ready;
  logic         host_cmd_wr = 1'b0;
  logic [4:0]   host_cmd_addr = '0;
  logic [127:0] host_cmd_data = '0;
  logic         host_rsp_valid;
  logic         host_rsp_ready = 1'b0;
  logic [127:0] host_rsp_data;
  logic [1:0]   host_rsp_err;
  logic         lkup_active = 1'b0;
  logic         tbl_wr_req;
  logic [4:0]   tbl_wr_addr;
  logic [127:0] tbl_wr_data;
  logic         tbl_wr_ack = 1'b0;
  logic         tbl_rd_req;
  logic [4:0]   tbl_rd_addr;
  logic [127:0] tbl_rd_data = '0;
  logic         tbl_rd_ack = 1'b0;
  logic [31:0]  wr_count;
  logic [31:0]  rd_count;
  logic [31:0]  err_count;

  lpm_tbl_access_ctrl dut (
    .AXI_ACLK       (clk),
    .AXI_RESETN     (rst_n),
    .host_cmd_valid (host_cmd_valid),
    .host_cmd_ready (host_cmd_ready),
    .host_cmd_wr    (host_cmd_wr),
    .host_cmd_addr  (host_cmd_addr),
    .host_cmd_data  (host_cmd_data),
    .host_rsp_valid (host_rsp_valid),
    .host_rsp_ready (host_rsp_ready),
    .host_rsp_data  (host_rsp_data),
    .host_rsp_err   (host_rsp_err),
    .lkup_active    (lkup_active),
    .tbl_wr_req     (tbl_wr_req),
    .tbl_wr_addr    (tbl_wr_addr),
    .tbl_wr_data    (tbl_wr_data),
    .tbl_wr_ack     (tbl_wr_ack),
    .tbl_rd_req     (tbl_rd_req),
    .tbl_rd_addr    (tbl_rd_addr),
    .tbl_rd_data    (tbl_rd_data),
    .tbl_rd_ack     (tbl_rd_ack),
    .wr_count       (wr_count),
    .rd_count       (rd_count),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  // Table emulator: latches writes at the pulse, acks after a delay
  // (0 = never ack), drives read data only in the ack cycle.
  logic [127:0] tbl_mem [32] = '{default: '0};
  int           wr_delay = 1;
  int           rd_delay = 2;
  int           wr_cd = 0;
  int           rd_cd = 0;
  int           wr_pulses = 0;
  int           rd_pulses = 0;
  logic [4:0]   rd_a = '0;
  logic [4:0]   last_wr_addr = '0;

  always @(negedge clk) begin
    tbl_wr_ack  = 1'b0;
    tbl_rd_ack  = 1'b0;
    tbl_rd_data = '0;
    if (!rst_n) begin
      wr_cd = 0;
      rd_cd = 0;
    end else begin
      if (wr_cd > 0) begin
        wr_cd--;
        if (wr_cd == 0) tbl_wr_ack = 1'b1;
      end
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) begin
          tbl_rd_ack  = 1'b1;
          tbl_rd_data = tbl_mem[rd_a];
        end
      end
      if (tbl_wr_req) begin
        wr_pulses++;
        last_wr_addr = tbl_wr_addr;
        tbl_mem[tbl_wr_addr] = tbl_wr_data;
        wr_cd = wr_delay;
      end
      if (tbl_rd_req) begin
        rd_pulses++;
        rd_a  = tbl_rd_addr;
        rd_cd = rd_delay;
      end
    end
  end

  int           n_assert = 0;
  int           n_fail = 0;
  logic [127:0] shadow [32] = '{default: '0};
  int           exp_wr = 0;
  int           exp_rd = 0;
  int           exp_err = 0;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // busy > 0: lkup_active high for that many cycles after accept;
  // busy < 0: left high (caller clears it).
  task automatic do_cmd(input bit wr, input logic [4:0] a,
                        input logic [127:0] d, input int busy,
                        output logic [127:0] rdata,
                        output logic [1:0] err, output int cyc);
    int n;
    @(negedge clk);
    host_cmd_wr    = wr;
    host_cmd_addr  = a;
    host_cmd_data  = d;
    host_cmd_valid = 1'b1;
    if (busy != 0) lkup_active = 1'b1;
    n = 0;
    while (!host_cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready", 128'(host_cmd_ready), 128'(1));
    @(negedge clk);
    host_cmd_valid = 1'b0;
    if (busy > 0) begin
      fork
        begin
          repeat (busy) @(negedge clk);
          lkup_active = 1'b0;
        end
      join_none
    end
    cyc = 0;
    while (!host_rsp_valid && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("rsp_valid", 128'(host_rsp_valid), 128'(1));
    rdata = host_rsp_data;
    err   = host_rsp_err;
    host_rsp_ready = 1'b1;
    @(negedge clk);
    host_rsp_ready = 1'b0;
    check("rsp_drop", 128'(host_rsp_valid), 128'(0));
    n = 0;
    while ((wr_cd != 0 || rd_cd != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  // Expected outcome derived from the access rules, then compared.
  task automatic run_cmd(input bit wr, input logic [4:0] a,
                         input logic [127:0] d, input int busy,
                         input int dly);
    logic [127:0] rdata;
    logic [1:0]   err;
    int           cyc;
    bit           q_to;
    bit           a_to;
    int           e_cyc;
    int           e_err;
    logic [127:0] e_data;
    int           p0;
    q_to = wr && (busy < 0 || busy >= QUIET_TO);
    a_to = !q_to && (dly == 0 || dly > ACK_TO);
    e_err = q_to ? 2 : (a_to ? 1 : 0);
    if (q_to) e_cyc = QUIET_TO;
    else if (wr) e_cyc = busy + 2 + (a_to ? ACK_TO : dly);
    else e_cyc = 1 + (a_to ? ACK_TO : dly);
    if (wr) begin
      wr_delay = dly;
      p0 = wr_pulses;
    end else begin
      rd_delay = dly;
      p0 = rd_pulses;
    end
    e_data = (!wr && !a_to) ? shadow[a] : '0;
    do_cmd(wr, a, d, busy, rdata, err, cyc);
    if (busy < 0) lkup_active = 1'b0;
    if (wr && !q_to) shadow[a] = d;
    if (wr && e_err == 0) exp_wr++;
    if (!wr && e_err == 0) exp_rd++;
    if (e_err != 0) exp_err++;
    check("rsp_err", 128'(err), 128'(e_err));
    check("rsp_data", rdata, e_data);
    check("latency", 128'(cyc), 128'(e_cyc));
    check("pulses", 128'(wr ? wr_pulses : rd_pulses),
          128'(q_to ? p0 : p0 + 1));
    check("wr_count", 128'(wr_count), 128'(exp_wr));
    check("rd_count", 128'(rd_count), 128'(exp_rd));
    check("err_count", 128'(err_count), 128'(exp_err));
  endtask

  initial begin
    logic [127:0] d1;
    logic [127:0] dbeef;
    int           p0;
    int           n;
    d1    = 128'h00000001_0A000001_FFFFFF00_0A000000;
    dbeef = 128'hDEADBEEF_00000000_12345678_0000BEEF;

    repeat (3) @(negedge clk);
    check("rst_ready", 128'(host_cmd_ready), 128'(0));
    check("rst_rsp_valid", 128'(host_rsp_valid), 128'(0));
    check("rst_wr_req", 128'(tbl_wr_req), 128'(0));
    check("rst_wr_data", tbl_wr_data, 128'(0));
    check("rst_wr_count", 128'(wr_count), 128'(0));
    rst_n = 1'b1;

    run_cmd(1'b1, 5'd3, d1, 0, 1);
    check("t1_wr_addr", 128'(last_wr_addr), 128'(3));
    check("t1_wr_count", 128'(wr_count), 128'(1));

    run_cmd(1'b1, 5'd3, d1, 50, 1);

    run_cmd(1'b1, 5'd4, ~d1, -1, 1);
    check("t3_err_count", 128'(err_count), 128'(1));

    run_cmd(1'b1, 5'd31, dbeef, 0, 3);
    run_cmd(1'b0, 5'd31, '0, 0, 2);
    check("t4_rd_count", 128'(rd_count), 128'(1));

    run_cmd(1'b0, 5'd3, '0, 0, 20);
    run_cmd(1'b0, 5'd3, '0, 0, 1);

    run_cmd(1'b1, 5'd9, d1 ^ dbeef, 0, 16);
    run_cmd(1'b1, 5'd10, dbeef, 0, 17);

    for (int i = 0; i < 25; i++) begin
      run_cmd(1'($urandom % 2), 5'($urandom % 32),
              {$urandom, $urandom, $urandom, $urandom},
              ($urandom % 4 == 0) ? int'($urandom_range(1, 40)) : 0,
              int'($urandom_range(1, 19)));
    end

    wr_delay = 0;
    p0 = wr_pulses;
    @(negedge clk);
    host_cmd_wr    = 1'b1;
    host_cmd_addr  = 5'd7;
    host_cmd_data  = dbeef;
    host_cmd_valid = 1'b1;
    n = 0;
    while (!host_cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    host_cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_pulse", 128'(wr_pulses), 128'(p0 + 1));
    #2 rst_n = 1'b0;
    #1;
    check("t6_ready", 128'(host_cmd_ready), 128'(0));
    check("t6_rsp_valid", 128'(host_rsp_valid), 128'(0));
    check("t6_wr_addr", 128'(tbl_wr_addr), 128'(0));
    check("t6_wr_data", tbl_wr_data, 128'(0));
    check("t6_rsp_data", host_rsp_data, 128'(0));
    check("t6_wr_count", 128'(wr_count), 128'(0));
    check("t6_rd_count", 128'(rd_count), 128'(0));
    check("t6_err_count", 128'(err_count), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_wr  = 0;
    exp_rd  = 0;
    exp_err = 0;
    repeat (25) @(negedge clk);
    check("t6_no_rsp", 128'(host_rsp_valid), 128'(0));
    check("t6_no_reissue", 128'(wr_pulses), 128'(p0 + 1));
    run_cmd(1'b0, 5'd31, '0, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
